// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 size/sign
// codes, timeout length and store lane-placement helpers.
package lsu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned TIMEOUT_CYCLES = 255;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // funct3 encodings; bit 2 set means zero-extend on loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size taken from funct3[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Legal encoding and natural alignment for the given byte offset
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~off[0];
      F3_LW:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for a store of the given size at the given offset
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the enables pick the right copy
  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] sz, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Ports: dmemReq_o/dmemWe_o request and write enable, dmemAddr_o word address,
// dmemWdata_o/dmemBe_o lane-placed data and byte enables, dmemRdata_i read
// word, dmemAck_i completion strobe.
interface load_store_unit_if;
  logic        dmemReq_o;
  logic        dmemWe_o;
  logic [31:0] dmemAddr_o;
  logic [31:0] dmemWdata_o;
  logic [3:0]  dmemBe_o;
  logic [31:0] dmemRdata_i;
  logic        dmemAck_i;

  modport master (
    output dmemReq_o, dmemWe_o, dmemAddr_o, dmemWdata_o, dmemBe_o,
    input  dmemRdata_i, dmemAck_i
  );

  modport slave (
    input  dmemReq_o, dmemWe_o, dmemAddr_o, dmemWdata_o, dmemBe_o,
    output dmemRdata_i, dmemAck_i
  );
endinterface

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension.
// Ports: rdata_i read word, offset_i byte offset, funct3_i size/sign,
// result_o extended 32-bit load value.
module load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;
  logic            sign_ext;

  // Shift the addressed lane down to bit 0, then extend by size
  always_comb begin
    shifted  = rdata_i >> {offset_i, 3'b000};
    sign_ext = ~funct3_i[2];
    result_o = rdata_i;
    case (funct3_i[1:0])
      SZ_BYTE: result_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory access in IDLE, issues it on the data
// bus, waits for ack (or times out), then reports writeback or error.
// Ports: clk_i/reset_i clock and async active-high reset; memEn_i, memWr_i,
// funct3_i, addr_i, storeData_i, rd_i describe the access; dmem is the
// data-memory bus; loadResult_o/loadrd_o writeback data and destination;
// wbValid_o completion pulse, busy_o stall, error_o fault pulse.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   memEn_i,
  input  logic                   memWr_i,
  input  logic [2:0]             funct3_i,
  input  logic [XLEN-1:0]        addr_i,
  input  logic [XLEN-1:0]        storeData_i,
  input  logic [4:0]             rd_i,
  load_store_unit_if.master      dmem,
  output logic signed [XLEN-1:0] loadResult_o,
  output logic [4:0]             loadrd_o,
  output logic                   wbValid_o,
  output logic                   busy_o,
  output logic                   error_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              wb_q, wb_d;
  logic [4:0]        lrd_q, lrd_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   align_res;

  load_align u_load_align (
    .rdata_i  (dmem.dmemRdata_i),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (align_res)
  );

  // State and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      wb_q    <= 1'b0;
      lrd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      wb_q    <= wb_d;
      lrd_q   <= lrd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    res_d   = res_q;
    wb_d    = 1'b0;
    lrd_d   = '0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Ack seen here belongs to nothing and is ignored
        if (memEn_i) begin
          if (access_ok(funct3_i, addr_i[1:0])) begin
            state_d = WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = memWr_i;
            addr_d  = {addr_i[XLEN-1:2], 2'b00};
            wdata_d = store_wdata(funct3_i[1:0], storeData_i);
            be_d    = store_be(funct3_i[1:0], addr_i[1:0]);
            off_d   = addr_i[1:0];
            f3_d    = funct3_i;
            rd_d    = rd_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (dmem.dmemAck_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wb_d    = 1'b1;
          if (!we_q) begin
            lrd_d = rd_q;
            res_d = align_res;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Last allowed wait cycle expired without ack: abandon the access
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.dmemReq_o   = req_q;
  assign dmem.dmemWe_o    = we_q;
  assign dmem.dmemAddr_o  = addr_q;
  assign dmem.dmemWdata_o = wdata_q;
  assign dmem.dmemBe_o    = be_q;

  assign loadResult_o = res_q;
  assign loadrd_o     = lrd_q;
  assign wbValid_o    = wb_q;
  assign busy_o       = (state_q == WAIT);
  assign error_o      = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a completion scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic               clk_i;
  logic               reset_i;
  logic               memEn_i;
  logic               memWr_i;
  logic [2:0]         funct3_i;
  logic [31:0]        addr_i;
  logic [31:0]        storeData_i;
  logic [4:0]         rd_i;
  logic signed [31:0] loadResult_o;
  logic [4:0]         loadrd_o;
  logic               wbValid_o;
  logic               busy_o;
  logic               error_o;

  load_store_unit_if dmem ();

  load_store_unit dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .memEn_i      (memEn_i),
    .memWr_i      (memWr_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .storeData_i  (storeData_i),
    .rd_i         (rd_i),
    .dmem         (dmem),
    .loadResult_o (loadResult_o),
    .loadrd_o     (loadrd_o),
    .wbValid_o    (wbValid_o),
    .busy_o       (busy_o),
    .error_o      (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_err;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          chk_res;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] last_res;

  // Completion monitor: pops the scoreboard on every wbValid/error pulse
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i) begin
      if (wbValid_o || error_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion: wbValid=%b error=%b, required none", wbValid_o, error_o);
        end else begin
          e = sb_q.pop_front();
          if (wbValid_o !== !e.is_err || error_o !== e.is_err) begin
            errors++;
            $display("FAIL completion_kind: wbValid=%b error=%b, required error=%b", wbValid_o, error_o, e.is_err);
          end
          checks++;
          if (loadrd_o !== e.rd) begin
            errors++;
            $display("FAIL loadrd: got %0d, required %0d", loadrd_o, e.rd);
          end
          if (e.chk_res) begin
            checks++;
            if (loadResult_o !== e.res) begin
              errors++;
              $display("FAIL loadResult: got %08h, required %08h", loadResult_o, e.res);
            end
            last_res = e.res;
          end
        end
      end else begin
        checks++;
        if (loadrd_o !== 5'd0 || loadResult_o !== last_res) begin
          errors++;
          $display("FAIL idle_hold: loadrd=%0d result=%08h, required 0 and %08h", loadrd_o, loadResult_o, last_res);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (dmem.dmemReq_o !== 1'b0 || dmem.dmemWe_o !== 1'b0 || dmem.dmemAddr_o !== 32'd0 ||
        dmem.dmemWdata_o !== 32'd0 || dmem.dmemBe_o !== 4'd0 || loadResult_o !== 32'd0 ||
        loadrd_o !== 5'd0 || wbValid_o !== 1'b0 || busy_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b be=%h addr=%08h res=%08h busy=%b, required all zero",
               dmem.dmemReq_o, dmem.dmemBe_o, dmem.dmemAddr_o, loadResult_o, busy_o);
    end
    reset_i = 1'b0;
  endtask

  // Issues one access from the current negedge and acks after ack_wait WAIT cycles
  task automatic do_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] rdata,
                           input int ack_wait, input logic [31:0] exp_res,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    exp_t e;
    memEn_i = 1'b1; memWr_i = wr; funct3_i = f3; addr_i = addr; storeData_i = sdata; rd_i = rd;
    e.is_err = 1'b0; e.rd = wr ? 5'd0 : rd; e.res = exp_res; e.chk_res = !wr;
    sb_q.push_back(e);
    @(negedge clk_i);
    memEn_i = 1'b0;
    for (int i = 0; i <= ack_wait; i++) begin
      checks++;
      if (busy_o !== 1'b1 || dmem.dmemReq_o !== 1'b1 || dmem.dmemWe_o !== wr ||
          dmem.dmemAddr_o !== {addr[31:2], 2'b00} ||
          (wr && (dmem.dmemBe_o !== exp_be || dmem.dmemWdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL bus_wait%0d: busy=%b req=%b we=%b addr=%08h be=%b wdata=%08h, required 1 1 %b %08h %b %08h",
                 i, busy_o, dmem.dmemReq_o, dmem.dmemWe_o, dmem.dmemAddr_o, dmem.dmemBe_o,
                 dmem.dmemWdata_o, wr, {addr[31:2], 2'b00}, exp_be, exp_wdata);
      end
      if (i == ack_wait) begin
        dmem.dmemAck_i   = 1'b1;
        dmem.dmemRdata_i = rdata;
      end
      @(negedge clk_i);
    end
    dmem.dmemAck_i   = 1'b0;
    dmem.dmemRdata_i = $urandom;
    checks++;
    if (busy_o !== 1'b0 || dmem.dmemReq_o !== 1'b0) begin
      errors++;
      $display("FAIL release: busy=%b req=%b, required 0 0", busy_o, dmem.dmemReq_o);
    end
  endtask

  task automatic test_loads();
    do_access(1'b0, F3_LW,  32'h100, 32'h0, 5'd5,  32'hDEADBEEF, 2, 32'hDEADBEEF, 4'h0, 32'h0);
    do_access(1'b0, F3_LB,  32'h103, 32'h0, 5'd6,  32'h80FFFFFF, 1, 32'hFFFFFF80, 4'h0, 32'h0);
    do_access(1'b0, F3_LBU, 32'h103, 32'h0, 5'd7,  32'h80FFFFFF, 0, 32'h00000080, 4'h0, 32'h0);
    do_access(1'b0, F3_LHU, 32'h102, 32'h0, 5'd8,  32'h8001ABCD, 3, 32'h00008001, 4'h0, 32'h0);
    do_access(1'b0, F3_LH,  32'h102, 32'h0, 5'd9,  32'h8001ABCD, 0, 32'hFFFF8001, 4'h0, 32'h0);
    do_access(1'b0, F3_LB,  32'h100, 32'h0, 5'd10, 32'h1234567F, 1, 32'h0000007F, 4'h0, 32'h0);
    do_access(1'b0, F3_LH,  32'h100, 32'h0, 5'd31, 32'h12348000, 0, 32'hFFFF8000, 4'h0, 32'h0);
    do_access(1'b0, F3_LBU, 32'h101, 32'h0, 5'd11, 32'h1234C67F, 0, 32'h000000C6, 4'h0, 32'h0);
  endtask

  task automatic test_stores();
    do_access(1'b1, 3'b000, 32'h201, 32'h000000A5, 5'd3, 32'h0, 1, 32'h0, 4'b0010, 32'hA5A5A5A5);
    do_access(1'b1, 3'b001, 32'h202, 32'hFFFF1234, 5'd4, 32'h0, 0, 32'h0, 4'b1100, 32'h12341234);
    do_access(1'b1, 3'b001, 32'h200, 32'h0000BEEF, 5'd4, 32'h0, 2, 32'h0, 4'b0011, 32'hBEEFBEEF);
    do_access(1'b1, 3'b010, 32'h204, 32'hCAFEBABE, 5'd1, 32'h0, 0, 32'h0, 4'b1111, 32'hCAFEBABE);
    do_access(1'b1, 3'b000, 32'h203, 32'h0000003C, 5'd2, 32'h0, 0, 32'h0, 4'b1000, 32'h3C3C3C3C);
  endtask

  task automatic test_rd_zero();
    do_access(1'b0, F3_LW, 32'h300, 32'h0, 5'd0, 32'h11112222, 1, 32'h11112222, 4'h0, 32'h0);
  endtask

  task automatic test_bad_access(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    exp_t e;
    memEn_i = 1'b1; memWr_i = wr; funct3_i = f3; addr_i = addr; rd_i = 5'd12;
    e.is_err = 1'b1; e.rd = 5'd0; e.res = 32'h0; e.chk_res = 1'b0;
    sb_q.push_back(e);
    @(negedge clk_i);
    memEn_i = 1'b0;
    checks++;
    if (dmem.dmemReq_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_access_req f3=%b addr=%08h: req=%b busy=%b, required 0 0", f3, addr, dmem.dmemReq_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_access_pulse f3=%b: error=%b busy=%b, required 0 0", f3, error_o, busy_o);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n;
    memEn_i = 1'b1; memWr_i = 1'b0; funct3_i = F3_LW; addr_i = 32'h400; rd_i = 5'd13;
    e.is_err = 1'b1; e.rd = 5'd0; e.res = 32'h0; e.chk_res = 1'b0;
    sb_q.push_back(e);
    @(negedge clk_i);
    memEn_i = 1'b0;
    n = 0;
    while (dmem.dmemReq_o === 1'b1 && n < 400) begin
      n++;
      @(negedge clk_i);
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL timeout_len: req high %0d cycles, required 255", n);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b, required 0", busy_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_ack_in_idle();
    dmem.dmemAck_i   = 1'b1;
    dmem.dmemRdata_i = 32'h55555555;
    @(negedge clk_i);
    dmem.dmemAck_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || wbValid_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_idle: busy=%b wb=%b err=%b, required 0 0 0", busy_o, wbValid_o, error_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    memEn_i = 1'b1; memWr_i = 1'b0; funct3_i = F3_LW; addr_i = 32'h500; rd_i = 5'd14;
    e.is_err = 1'b0; e.rd = 5'd14; e.res = 32'h0; e.chk_res = 1'b1;
    sb_q.push_back(e);
    @(negedge clk_i);
    memEn_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    last_res = 32'h0;
    sb_q.delete();
    #1;
    checks++;
    if (dmem.dmemReq_o !== 1'b0 || busy_o !== 1'b0 || wbValid_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: req=%b busy=%b wb=%b err=%b, required 0 0 0 0",
               dmem.dmemReq_o, busy_o, wbValid_o, error_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    do_access(1'b0, F3_LW, 32'h100, 32'h0, 5'd5, 32'h0BADF00D, 1, 32'h0BADF00D, 4'h0, 32'h0);
  endtask

  initial begin
    checks = 0; errors = 0; last_res = 32'h0;
    reset_i = 1'b1; memEn_i = 1'b0; memWr_i = 1'b0; funct3_i = 3'b0;
    addr_i = 32'h0; storeData_i = 32'h0; rd_i = 5'd0;
    dmem.dmemAck_i = 1'b0; dmem.dmemRdata_i = 32'h0;

    test_reset();
    test_loads();
    test_stores();
    test_rd_zero();
    test_bad_access(1'b0, F3_LW,  32'h102);
    test_bad_access(1'b0, F3_LH,  32'h101);
    test_bad_access(1'b0, F3_LHU, 32'h103);
    test_bad_access(1'b1, 3'b010, 32'h203);
    test_bad_access(1'b1, 3'b001, 32'h201);
    test_bad_access(1'b0, 3'b011, 32'h100);
    test_bad_access(1'b0, 3'b110, 32'h100);
    test_bad_access(1'b1, 3'b111, 32'h100);
    test_ack_in_idle();
    test_timeout();
    test_reset_mid_wait();
    @(negedge clk_i);
    @(negedge clk_i);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_i  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: memEn_i  in  1  memory access requested by the instruction in this stage.
REQ-004 SHALL have: memWr_i  in  1  1 = store, 0 = load (valid with memEn_i).
REQ-005 SHALL have: funct3_i  in  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-006 SHALL have: addr_i  in  32  effective byte address from ALU.
REQ-007 SHALL have: storeData_i  in  32  store operand (rs2 value).
REQ-008 SHALL have: rd_i  in  5  load destination register.
REQ-009 SHALL have: dmemReq_o / dmemWe_o  out  1 / 1  data-memory request, write enable.
REQ-010 SHALL have: dmemAddr_o / dmemWdata_o / dmemBe_o  out  32 / 32 / 4  word-aligned address, lane-placed data, byte enables.
REQ-011 SHALL have: dmemRdata_i / dmemAck_i  in  32 / 1  read word, completion strobe.
REQ-012 SHALL have: loadResult_o  out  32 signed  extended load data for forwarding and writeback.
REQ-013 SHALL have: loadrd_o  out  5  destination of the load completing this cycle, else 0.
REQ-014 SHALL have: wbValid_o / busy_o / error_o  out  1 / 1 / 1  completion pulse, upstream stall, fault pulse.

Function
REQ-015 SHALL implement FSM states IDLE and WAIT; inputs sampled only in IDLE.
REQ-016 IDLE, memEn_i=1, legal and aligned: SHALL register address, data, rd, size, sign, and direction; assert dmemReq_o next cycle; enter WAIT.
REQ-017 busy_o SHALL equal (state==WAIT); upstream holds inputs while busy_o=1.
REQ-018 WAIT: dmemReq_o, dmemWe_o, dmemAddr_o, dmemWdata_o, and dmemBe_o SHALL stay stable until the cycle dmemAck_i=1.
REQ-019 Ack on a load: the next cycle SHALL give wbValid_o=1, loadrd_o=rd, and loadResult_o=extended data for exactly one cycle, then return to IDLE.
REQ-020 Ack on a store: the next cycle SHALL give wbValid_o=1 and loadrd_o=0, then return to IDLE.
REQ-021 dmemAddr_o SHALL be {addr[31:2],2'b00}.
REQ-022 Store lanes: SB SHALL use be=1<<addr[1:0] with the byte replicated x4; SH SHALL use be=0011 or 1100 per addr[1] with the half replicated x2; SW SHALL use be=1111.
REQ-023 Load extraction SHALL select the lane by addr[1:0]; funct3[2]=0 SHALL sign-extend and funct3[2]=1 SHALL zero-extend.
REQ-024 LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL cause no request, give error_o=1 for one cycle next cycle, keep loadrd_o=0, and stay IDLE.
REQ-025 Illegal funct3 (011, 110, 111) SHALL be handled as REQ-024.
REQ-026 An 8-bit counter SHALL count WAIT cycles; at 255 with no ack it SHALL drop dmemReq_o, pulse error_o, and return to IDLE with no writeback.
REQ-027 A load with rd=0 SHALL perform the access and pulse wbValid_o, with loadrd_o=0.
REQ-028 loadrd_o SHALL be 0 and loadResult_o SHALL hold its last value whenever wbValid_o=0.
REQ-029 dmemAck_i asserted in IDLE SHALL be ignored.

Reset
REQ-030 reset_i SHALL force IDLE immediately, including mid-WAIT, with the request abandoned.
REQ-031 Under reset_i, all outputs and internal registers SHALL be 0.
REQ-032 The first access after reset SHALL be accepted on the first rising edge with reset_i=0.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the state enum, funct3 size/sign constants, and TIMEOUT_CYCLES=255.
REQ-034 Lane extraction and extension SHALL be a combinational sub-module load_align (inputs rdata, offset, funct3; output 32-bit result).

Verification
REQ-035 LW addr=0x100, rdata=0xDEADBEEF, ack after 2 cycles, rd=5 -> busy_o high 3 cycles, then wbValid_o=1, loadrd_o=5, loadResult_o=0xDEADBEEF.
REQ-036 LB addr=0x103, rdata=0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102, rdata=0x8001ABCD -> 0x00008001.
REQ-037 SB addr=0x201, data=0x000000A5 -> dmemAddr_o=0x200, be=0010, wdata=0xA5A5A5A5, loadrd_o=0 at completion.
REQ-038 LW addr=0x102 -> no dmemReq_o, error_o one-cycle pulse, busy_o stays 0.
REQ-039 Load with ack withheld -> dmemReq_o drops after 255 WAIT cycles, error_o pulses, no wbValid_o.
REQ-040 reset_i asserted in WAIT cycle 3 -> dmemReq_o=0 and busy_o=0 immediately; next LW completes normally.
